// File: rtl/trap_fsm_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes and FSM state encodings.
// Consumed by trap_prio and trap_fsm (optional TRAP_VECTORED_EN lives in trap_fsm).
package trap_fsm_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEpc   = 3'd1,
    StCause = 3'd2,
    StTval  = 3'd3,
    StStat  = 3'd4,
    StJump  = 3'd5,
    StMret  = 3'd6,
    StMjump = 3'd7
  } trap_state_e;

  typedef enum logic [1:0] {
    TvalZero = 2'd0,
    TvalInst = 2'd1,
    TvalPc   = 2'd2
  } tval_sel_e;

endpackage

// File: rtl/trap_prio.sv
// Combinational priority encoder choosing among exceptions, mret and masked interrupts.
// rsp_o is one-hot {external, software, timer} and only set when an interrupt wins.
module trap_prio
  import trap_fsm_pkg::*;
(
  input  logic        hx_valid_i,
  input  logic        mie_i,
  input  logic        ex_i,
  input  logic        soft_i,
  input  logic        tcmp_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  output logic        valid_o,
  output logic        mret_o,
  output logic        is_int_o,
  output logic [31:0] cause_o,
  output tval_sel_e   tval_sel_o,
  output logic [2:0]  rsp_o
);

  logic int_en;
  assign int_en = hx_valid_i & mie_i;

  always_comb begin
    valid_o    = 1'b0;
    mret_o     = 1'b0;
    is_int_o   = 1'b0;
    cause_o    = '0;
    tval_sel_o = TvalZero;
    rsp_o      = 3'b000;
    if (illegal_i) begin
      valid_o    = 1'b1;
      cause_o    = CAUSE_ILLEGAL;
      tval_sel_o = TvalInst;
    end else if (ebreak_i) begin
      valid_o    = 1'b1;
      cause_o    = CAUSE_EBREAK;
      tval_sel_o = TvalPc;
    end else if (ecall_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_ECALL;
    end else if (mret_i) begin
      valid_o = 1'b1;
      mret_o  = 1'b1;
    end else if (int_en && ex_i) begin
      valid_o  = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MEI;
      rsp_o    = 3'b100;
    end else if (int_en && soft_i) begin
      valid_o  = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MSI;
      rsp_o    = 3'b010;
    end else if (int_en && tcmp_i) begin
      valid_o  = 1'b1;
      is_int_o = 1'b1;
      cause_o  = CAUSE_MTI;
      rsp_o    = 3'b001;
    end
  end

endmodule

// File: rtl/trap_fsm.sv
// Trap sequencer: accepts traps/mret, runs the CSR save/restore sequence and redirects the PC.
// Define TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module trap_fsm
  import trap_fsm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hx_valid_i,
  input  logic              ex_trap_i,
  input  logic              tcmp_trap_i,
  input  logic              soft_trap_i,
  input  logic              mstatus_mie_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              illegal_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   inst_i,
  input  logic [XLEN-1:0]   inst_pc_i,
  input  logic [XLEN-1:0]   next_pc_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              pex_trap_rsp_o,
  output logic              ptcmp_trap_rsp_o,
  output logic              psoft_trap_rsp_o,
  output logic              hold_o,
  output logic              jump_o,
  output logic [XLEN-1:0]   jump_addr_o
);

  trap_state_e     state_q;
  logic [XLEN-1:0] cause_q, tval_q, epc_q;

  logic            p_valid, p_mret, p_is_int;
  logic [31:0]     p_cause;
  tval_sel_e       p_tval_sel;
  logic [2:0]      p_rsp;
  logic            accept;
  logic [XLEN-1:0] tval_d;

  trap_prio u_prio (
    .hx_valid_i (hx_valid_i),
    .mie_i      (mstatus_mie_i),
    .ex_i       (ex_trap_i),
    .soft_i     (soft_trap_i),
    .tcmp_i     (tcmp_trap_i),
    .ecall_i    (ecall_i),
    .ebreak_i   (ebreak_i),
    .illegal_i  (illegal_i),
    .mret_i     (mret_i),
    .valid_o    (p_valid),
    .mret_o     (p_mret),
    .is_int_o   (p_is_int),
    .cause_o    (p_cause),
    .tval_sel_o (p_tval_sel),
    .rsp_o      (p_rsp)
  );

  // A reset cycle never accepts, so no response pulse can clear pending state that is then lost.
  assign accept = p_valid && (state_q == StIdle) && !rst;

  always_comb begin
    unique case (p_tval_sel)
      TvalInst: tval_d = inst_i;
      TvalPc:   tval_d = inst_pc_i;
      default:  tval_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (p_mret) begin
              state_q <= StMret;
            end else begin
              state_q <= StEpc;
              cause_q <= XLEN'(p_cause);
              tval_q  <= tval_d;
              epc_q   <= p_is_int ? next_pc_i : inst_pc_i;
            end
          end
        end
        StEpc:   state_q <= StCause;
        StCause: state_q <= StTval;
        StTval:  state_q <= StStat;
        StStat:  state_q <= StJump;
        StJump:  state_q <= StIdle;
        StMret:  state_q <= StMjump;
        StMjump: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    csr_we_o         = 1'b0;
    csr_addr_o       = '0;
    csr_wdata_o      = '0;
    jump_o           = 1'b0;
    jump_addr_o      = '0;
    hold_o           = (state_q != StIdle) || accept;
    pex_trap_rsp_o   = accept && p_rsp[2];
    psoft_trap_rsp_o = accept && p_rsp[1];
    ptcmp_trap_rsp_o = accept && p_rsp[0];
    unique case (state_q)
      StEpc: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MEPC);
        csr_wdata_o = epc_q;
      end
      StCause: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
      end
      StTval: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MTVAL);
        csr_wdata_o = tval_q;
      end
      StStat: begin
        // MPIE <= MIE, MIE <= 0
        csr_we_o       = 1'b1;
        csr_addr_o     = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o    = csr_rdata_i;
        csr_wdata_o[7] = csr_rdata_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      StJump: begin
        csr_addr_o  = CSR_AW'(CSR_MTVEC);
        jump_o      = 1'b1;
        jump_addr_o = {csr_rdata_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1]) begin
          jump_addr_o = {csr_rdata_i[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
        end
`endif
      end
      StMret: begin
        // MIE <= MPIE, MPIE <= 1
        csr_we_o       = 1'b1;
        csr_addr_o     = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o    = csr_rdata_i;
        csr_wdata_o[3] = csr_rdata_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      StMjump: begin
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
  end

endmodule
